// File: rtl/ddr_write_merger_pkg.sv
// Shared types and helpers for the DDR write merger: FSM state encoding,
// data geometry and the byte-lane merge used when combining writes.
package ddr_write_merger_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int PKG_DATA_WIDTH = 64;
    localparam int BYTES          = PKG_DATA_WIDTH / 8;

    // Per byte lane: take the new byte where the enable is set, keep the old one otherwise.
    function automatic logic [PKG_DATA_WIDTH-1:0] byte_merge(
        input logic [PKG_DATA_WIDTH-1:0] old_data,
        input logic [PKG_DATA_WIDTH-1:0] new_data,
        input logic [BYTES-1:0]          mask
    );
        logic [PKG_DATA_WIDTH-1:0] res;
        res = old_data;
        for (int i = 0; i < BYTES; i++) begin
            if (mask[i]) begin
                res[8*i +: 8] = new_data[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_data[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ddr_write_merger.sv
// Holds one pending DDR word and folds successive same-word writes into it,
// releasing it on address change, full mask, timeout or explicit flush.
module ddr_write_merger
    import ddr_write_merger_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = PKG_DATA_WIDTH,
    parameter int TIMEOUT    = 16
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    flush,
    input  logic                    in_wr,
    input  logic [ADDR_WIDTH-1:0]   in_addr,
    input  logic [DATA_WIDTH/8-1:0] in_mask,
    input  logic [DATA_WIDTH-1:0]   in_din,
    output logic                    in_wait_n,
    output logic                    out_wr,
    output logic [ADDR_WIDTH-1:0]   out_addr,
    output logic [DATA_WIDTH/8-1:0] out_mask,
    output logic [DATA_WIDTH-1:0]   out_din,
    input  logic                    out_wait_n,
    output logic                    idle
);

    localparam int MW = DATA_WIDTH / 8;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    state_e                  state_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [MW-1:0]           mask_r;
    logic [DATA_WIDTH-1:0]   data_r;
    logic [TW-1:0]           timer_r;

    logic                    match_s;
    logic                    ready_s;
    logic                    take_s;
    logic                    load_s;
    logic [MW-1:0]           merged_mask_s;
    logic [DATA_WIDTH-1:0]   merged_data_s;

    // Upstream handshake and merge datapath; low 3 address bits never affect matching.
    always_comb begin
        match_s       = (in_addr[ADDR_WIDTH-1:3] == addr_r[ADDR_WIDTH-1:3]);
        merged_mask_s = mask_r | in_mask;
        merged_data_s = byte_merge(data_r, in_din, in_mask);
        case (state_r)
            ST_EMPTY: ready_s = 1'b1;
            ST_HOLD:  ready_s = match_s & ~flush;
            ST_DRAIN: ready_s = out_wait_n;
            default:  ready_s = 1'b0;
        endcase
        take_s = in_wr & ready_s;
        // A transfer with no byte enables carries nothing and is dropped.
        load_s = take_s & (|in_mask);
    end

    // Merger state machine and held-word registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_EMPTY;
            addr_r  <= {ADDR_WIDTH{1'b0}};
            mask_r  <= {MW{1'b0}};
            data_r  <= {DATA_WIDTH{1'b0}};
            timer_r <= {TW{1'b0}};
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (load_s) begin
                        addr_r  <= in_addr;
                        mask_r  <= in_mask;
                        data_r  <= merged_data_s;
                        timer_r <= {TW{1'b0}};
                        state_r <= (&in_mask) ? ST_DRAIN : ST_HOLD;
                    end else begin
                        state_r <= ST_EMPTY;
                    end
                end
                ST_HOLD: begin
                    if (flush) begin
                        state_r <= ST_DRAIN;
                    end else if (in_wr && match_s) begin
                        // A merge always restarts the hold window, even on the expiry cycle.
                        mask_r  <= merged_mask_s;
                        data_r  <= merged_data_s;
                        timer_r <= {TW{1'b0}};
                        state_r <= (&merged_mask_s) ? ST_DRAIN : ST_HOLD;
                    end else if (in_wr) begin
                        state_r <= ST_DRAIN;
                    end else if (timer_r == TIMER_LAST) begin
                        state_r <= ST_DRAIN;
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (!out_wait_n) begin
                        state_r <= ST_DRAIN;
                    end else if (load_s) begin
                        // Back-to-back handoff: the next word loads as the current one leaves.
                        addr_r  <= in_addr;
                        mask_r  <= in_mask;
                        data_r  <= merged_data_s;
                        timer_r <= {TW{1'b0}};
                        state_r <= (&in_mask) ? ST_DRAIN : ST_HOLD;
                    end else begin
                        state_r <= ST_EMPTY;
                    end
                end
                default: begin
                    state_r <= ST_EMPTY;
                end
            endcase
        end
    end

    assign in_wait_n = ready_s;
    assign out_wr    = (state_r == ST_DRAIN);
    assign idle      = (state_r == ST_EMPTY);
    assign out_addr  = addr_r;
    assign out_mask  = mask_r;
    assign out_din   = data_r;

endmodule

// File: tb/tb_ddr_write_merger.sv
// Directed bench for ddr_write_merger with a scoreboard of expected DDR writes.
module tb_ddr_write_merger;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int MW = DW / 8;

    typedef struct {
        logic [AW-1:0] addr;
        logic [MW-1:0] mask;
        logic [DW-1:0] din;
    } wr_t;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          flush;
    logic          in_wr;
    logic [AW-1:0] in_addr;
    logic [MW-1:0] in_mask;
    logic [DW-1:0] in_din;
    logic          in_wait_n;
    logic          out_wr;
    logic [AW-1:0] out_addr;
    logic [MW-1:0] out_mask;
    logic [DW-1:0] out_din;
    logic          out_wait_n;
    logic          idle;

    int  errors = 0;
    int  checks = 0;
    int  wr_count = 0;
    wr_t exp_q[$];

    ddr_write_merger #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(16)) dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .in_wr(in_wr), .in_addr(in_addr), .in_mask(in_mask), .in_din(in_din),
        .in_wait_n(in_wait_n), .out_wr(out_wr), .out_addr(out_addr),
        .out_mask(out_mask), .out_din(out_din), .out_wait_n(out_wait_n),
        .idle(idle)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [DW-1:0] lane_mask(input logic [MW-1:0] m);
        logic [DW-1:0] r;
        for (int i = 0; i < MW; i++) r[8*i +: 8] = m[i] ? 8'hFF : 8'h00;
        return r;
    endfunction

    // Scoreboard: every completed DDR write is popped and compared
    always @(negedge clock) begin
        if (reset_n && out_wr && out_wait_n) begin
            wr_t e;
            wr_count++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {32'd0, out_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("sb_addr", {32'd0, out_addr}, {32'd0, e.addr});
                chk("sb_mask", {56'd0, out_mask}, {56'd0, e.mask});
                chk("sb_din", out_din & lane_mask(e.mask), e.din & lane_mask(e.mask));
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic wr, input logic [AW-1:0] a, input logic [MW-1:0] m,
                         input logic [DW-1:0] d);
        in_wr = wr; in_addr = a; in_mask = m; in_din = d;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [MW-1:0] m, input logic [DW-1:0] d);
        wr_t e;
        e.addr = a; e.mask = m; e.din = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            cyc();
            n++;
        end
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int n;
        int k;
        int base_wr;
        logic prev_stall;
        logic [AW-1:0] s_addr;
        logic [MW-1:0] s_mask;
        logic [DW-1:0] s_din;
        logic [DW-1:0] words [4];

        reset_n = 1'b0; flush = 1'b0; out_wait_n = 1'b1;
        drive(1'b0, 32'h0, 8'h00, 64'h0);
        #2;
        chk("rst_idle", 64'(idle), 64'd1);
        chk("rst_out_wr", 64'(out_wr), 64'd0);
        chk("rst_in_wait_n", 64'(in_wait_n), 64'd1);
        chk("rst_out_addr", {32'd0, out_addr}, 64'd0);
        chk("rst_out_mask", {56'd0, out_mask}, 64'd0);
        chk("rst_out_din", out_din, 64'd0);
        cyc();
        reset_n = 1'b1;
        cyc();

        // Zero-mask write from EMPTY is ignored
        drive(1'b1, 32'h80, 8'h00, 64'hDEAD_BEEF_DEAD_BEEF);
        cyc();
        drive(1'b0, 32'h0, 8'h00, 64'h0);
        #1;
        chk("zero_mask_idle", 64'(idle), 64'd1);

        // Two halves merge into one write
        base_wr = wr_count;
        drive(1'b1, 32'h100, 8'h0F, 64'hAAAA_AAAA_1122_3344);
        #1;
        chk("merge_ready0", 64'(in_wait_n), 64'd1);
        push(32'h100, 8'hFF, 64'h5566_7788_1122_3344);
        cyc();
        drive(1'b1, 32'h104, 8'hF0, 64'h5566_7788_BBBB_BBBB);
        #1;
        chk("merge_ready1", 64'(in_wait_n), 64'd1);
        cyc();
        drive(1'b0, 32'h0, 8'h00, 64'h0);
        #1;
        chk("merge_out_wr", 64'(out_wr), 64'd1);
        wait_drain("merge_drain");
        repeat (3) cyc();
        chk("merge_one_write", 64'(wr_count - base_wr), 64'd1);

        // Address change forces the held word out
        drive(1'b1, 32'h100, 8'h0F, 64'h0000_0000_0102_0304);
        push(32'h100, 8'h0F, 64'h0000_0000_0102_0304);
        cyc();
        drive(1'b1, 32'h200, 8'h0F, 64'h0000_0000_0A0B_0C0D);
        #1;
        chk("addr_chg_stall", 64'(in_wait_n), 64'd0);
        cyc();
        chk("addr_chg_drain", 64'(out_wr), 64'd1);
        chk("addr_chg_ready", 64'(in_wait_n), 64'd1);
        push(32'h200, 8'h0F, 64'h0000_0000_0A0B_0C0D);
        cyc();
        drive(1'b0, 32'h0, 8'h00, 64'h0);
        wait_drain("addr_chg_timeout_drain");

        // Lone partial write drains after exactly TIMEOUT cycles
        repeat (2) cyc();
        drive(1'b1, 32'h40, 8'h03, 64'h0000_0000_0000_BEEF);
        push(32'h40, 8'h03, 64'h0000_0000_0000_BEEF);
        cyc();
        drive(1'b0, 32'h0, 8'h00, 64'h0);
        n = 0;
        while (!out_wr && n < 40) begin
            cyc();
            n++;
        end
        chk("timeout_latency", 64'(n), 64'd16);
        wait_drain("timeout_drain");

        // Full-mask stream with a 5-cycle DDR stall
        repeat (2) cyc();
        for (int i = 0; i < 4; i++) words[i] = {$urandom(), $urandom()};
        k = 0; n = 0; prev_stall = 1'b0;
        s_addr = '0; s_mask = '0; s_din = '0;
        while ((k < 4 || exp_q.size() != 0) && n < 40) begin
            if (k < 4) drive(1'b1, 32'h1000 + 32'(8 * k), 8'hFF, words[k]);
            else drive(1'b0, 32'h0, 8'h00, 64'h0);
            out_wait_n = !(n >= 2 && n < 7);
            #1;
            if (!out_wait_n && out_wr) begin
                chk("bp_in_wait_n", 64'(in_wait_n), 64'd0);
                if (prev_stall) begin
                    chk("bp_stable_addr", {32'd0, out_addr}, {32'd0, s_addr});
                    chk("bp_stable_din", out_din, s_din);
                    chk("bp_stable_mask", {56'd0, out_mask}, {56'd0, s_mask});
                end
                prev_stall = 1'b1;
                s_addr = out_addr; s_mask = out_mask; s_din = out_din;
            end else begin
                prev_stall = 1'b0;
            end
            if (in_wr && in_wait_n) begin
                push(in_addr, in_mask, in_din);
                k++;
            end
            cyc();
            n++;
        end
        out_wait_n = 1'b1;
        chk("bp_words_taken", 64'(k), 64'd4);
        chk("bp_queue_empty", 64'(exp_q.size()), 64'd0);

        // Flush beats a simultaneous matching write
        drive(1'b0, 32'h0, 8'h00, 64'h0);
        repeat (2) cyc();
        drive(1'b1, 32'h300, 8'h0F, 64'h0000_0000_1111_2222);
        push(32'h300, 8'h0F, 64'h0000_0000_1111_2222);
        cyc();
        drive(1'b1, 32'h300, 8'hF0, 64'h3333_4444_0000_0000);
        flush = 1'b1;
        #1;
        chk("flush_stall", 64'(in_wait_n), 64'd0);
        cyc();
        flush = 1'b0;
        #1;
        chk("flush_out_wr", 64'(out_wr), 64'd1);
        chk("flush_unmerged", {56'd0, out_mask}, 64'h0F);
        chk("flush_ready", 64'(in_wait_n), 64'd1);
        push(32'h300, 8'hF0, 64'h3333_4444_0000_0000);
        cyc();
        drive(1'b0, 32'h0, 8'h00, 64'h0);
        wait_drain("flush_drain");

        // Reset while stalled in DRAIN discards the word
        repeat (2) cyc();
        out_wait_n = 1'b0;
        drive(1'b1, 32'h500, 8'hFF, 64'h0123_4567_89AB_CDEF);
        cyc();
        drive(1'b0, 32'h0, 8'h00, 64'h0);
        #1;
        chk("rst_pre_out_wr", 64'(out_wr), 64'd1);
        base_wr = wr_count;
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst_async_out_wr", 64'(out_wr), 64'd0);
        chk("rst_async_idle", 64'(idle), 64'd1);
        cyc();
        reset_n = 1'b1;
        out_wait_n = 1'b1;
        repeat (20) cyc();
        chk("rst_no_write", 64'(wr_count - base_wr), 64'd0);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
